// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID skid buffer: NOP encoding, FSM state
// encoding and the default-width beat layout.
package if_id_pkg;

   // addi x0,x0,0 -- shown to decode whenever no valid beat is present
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // Occupancy states: main entry only drives outputs in ONE/FULL,
   // skid entry is occupied only in FULL.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Default-width beat as carried between fetch and decode
   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc_plus_4;
      logic        fault;
   } beat_t;

endpackage

// File: rtl/if_id_skid_buffer_if.sv
// Fetch-to-decode boundary bundle.
//
// Handshake: a beat transfers on a clock edge where valid & ready are both 1.
// A producer must hold valid and its data stable until the transfer happens;
// ready may change freely and never depends combinationally on valid.
// The buffer is the consumer on the in_* side and the producer on the out_*
// side; flush and stall_cycles are sideband.
interface if_id_skid_buffer_if #(
   parameter int INSN_W      = 32,
   parameter int PC_W        = 32,
   parameter int STALL_CNT_W = 16
);
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [INSN_W-1:0]      in_ins;
   logic [PC_W-1:0]        in_pc;
   logic [PC_W-1:0]        in_pc_plus_4;
   logic                   in_fault;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSN_W-1:0]      out_ins;
   logic [PC_W-1:0]        out_pc;
   logic [PC_W-1:0]        out_pc_plus_4;
   logic                   out_fault;
   logic [STALL_CNT_W-1:0] stall_cycles;
   logic [1:0]             dbg_state;

   // Buffer side
   modport slave (
      input  flush, in_valid, in_ins, in_pc, in_pc_plus_4, in_fault, out_ready,
      output in_ready, out_valid, out_ins, out_pc, out_pc_plus_4, out_fault,
             stall_cycles, dbg_state
   );

   // Pipeline side (fetch + decode + control)
   modport master (
      output flush, in_valid, in_ins, in_pc, in_pc_plus_4, in_fault, out_ready,
      input  in_ready, out_valid, out_ins, out_pc, out_pc_plus_4, out_fault,
             stall_cycles, dbg_state
   );
endinterface

// File: rtl/if_id_stall_counter.sv
// Saturating counter of decode-stall cycles. Cleared only by reset.
module if_id_stall_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Increment unless already at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline boundary: 2-entry valid/ready skid buffer with flush,
// NOP presentation on empty output, fault tag pass-through and a
// saturating stall counter. in_ready comes straight from a flop so decode
// backpressure never reaches fetch combinationally.
module if_id_skid_buffer
   import if_id_pkg::*;
#(
   parameter int                INSN_W      = 32,
   parameter int                PC_W        = 32,
   parameter logic [INSN_W-1:0] NOP_INSN    = INSN_W'(if_id_pkg::NOP_INSN),
   parameter int                STALL_CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst,
   if_id_skid_buffer_if.slave  bus
);

   typedef struct packed {
      logic [INSN_W-1:0] ins;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   pc_plus_4;
      logic              fault;
   } entry_t;

   localparam entry_t ENTRY_RST = '{ins: NOP_INSN, pc: '0, pc_plus_4: '0, fault: 1'b0};

   logic [1:0] state_q,    state_d;
   entry_t     main_q,     main_d;
   entry_t     skid_q,     skid_d;
   logic       in_ready_q, in_ready_d;

   logic       out_valid;
   logic       push;
   logic       pop;
   entry_t     in_beat;
   logic [STALL_CNT_W-1:0] stall_cnt;

   assign out_valid = (state_q != ST_EMPTY);
   assign push      = bus.in_valid & in_ready_q;
   assign pop       = out_valid & bus.out_ready;

   assign in_beat.ins       = bus.in_ins;
   assign in_beat.pc        = bus.in_pc;
   assign in_beat.pc_plus_4 = bus.in_pc_plus_4;
   assign in_beat.fault     = bus.in_fault;

   // Next occupancy and entry contents; flush overrides everything
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (bus.flush) begin
         // Push in this cycle is dropped; a pop is simply consumed.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  main_d  = in_beat;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_d = in_beat;
               end else if (push) begin
                  skid_d  = in_beat;
                  state_d = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a pop can happen
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Registered ready: accept whenever the next state leaves room
   always_comb begin
      in_ready_d = (state_d != ST_FULL);
   end

   // State and storage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= ENTRY_RST;
         skid_q     <= ENTRY_RST;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   if_id_stall_counter #(
      .W (STALL_CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~bus.out_ready),
      .count (stall_cnt)
   );

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid;
   assign bus.out_ins       = out_valid ? main_q.ins : NOP_INSN;
   assign bus.out_pc        = main_q.pc;
   assign bus.out_pc_plus_4 = main_q.pc_plus_4;
   assign bus.out_fault     = out_valid & main_q.fault;
   assign bus.stall_cycles  = stall_cnt;
   assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for the IF/ID skid buffer (stall counter built 4 bits wide).
module tb_if_id_skid_buffer;
   import if_id_pkg::*;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   if_id_skid_buffer_if #(.INSN_W(32), .PC_W(32), .STALL_CNT_W(4)) bus ();

   if_id_skid_buffer #(
      .INSN_W      (32),
      .PC_W        (32),
      .STALL_CNT_W (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock: 10-unit period, active edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'hA500_0000;
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic f);
      bus.in_valid     = v;
      bus.in_pc        = pc;
      bus.in_pc_plus_4 = pc + 32'd4;
      bus.in_ins       = ins_of(pc);
      bus.in_fault     = f;
   endtask

   task automatic check_beat(input string tag, input logic [31:0] pc);
      check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".pc"},    64'(bus.out_pc), 64'(pc));
      check({tag, ".pc4"},   64'(bus.out_pc_plus_4), 64'(pc + 32'd4));
      check({tag, ".ins"},   64'(bus.out_ins), 64'(ins_of(pc)));
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Reset values
      check("rst.valid", 64'(bus.out_valid), 64'd0);
      check("rst.ins",   64'(bus.out_ins), 64'h13);
      check("rst.pc",    64'(bus.out_pc), 64'd0);
      check("rst.pc4",   64'(bus.out_pc_plus_4), 64'd0);
      check("rst.fault", 64'(bus.out_fault), 64'd0);
      check("rst.ready", 64'(bus.in_ready), 64'd1);
      check("rst.stall", 64'(bus.stall_cycles), 64'd0);

      // Streaming with decode always ready
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h100, 1'b0);
      step();
      check_beat("str0", 32'h100);
      check("str0.ready", 64'(bus.in_ready), 64'd1);
      drive(1'b1, 32'h104, 1'b0);
      step();
      check_beat("str1", 32'h104);
      check("str1.ready", 64'(bus.in_ready), 64'd1);
      drive(1'b1, 32'h108, 1'b0);
      step();
      check_beat("str2", 32'h108);
      drive(1'b0, 32'h0, 1'b0);
      step();
      check("str.drain.valid", 64'(bus.out_valid), 64'd0);
      check("str.drain.ins",   64'(bus.out_ins), 64'h13);
      check("str.stall",       64'(bus.stall_cycles), 64'd0);

      // Stall and skid
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h200, 1'b0);
      step();
      check_beat("stl0", 32'h200);
      drive(1'b1, 32'h204, 1'b0);
      step();
      check("stl.state", 64'(bus.dbg_state), 64'(ST_FULL));
      check("stl.ready", 64'(bus.in_ready), 64'd0);
      check_beat("stl.hold0", 32'h200);
      drive(1'b1, 32'h208, 1'b0);
      step();
      check_beat("stl.hold1", 32'h200);
      check("stl.ready1", 64'(bus.in_ready), 64'd0);
      step();
      check_beat("stl.hold2", 32'h200);
      check("stl.stall3", 64'(bus.stall_cycles), 64'd3);
      bus.out_ready = 1'b1;
      step();
      check_beat("stl.out1", 32'h204);
      check("stl.ready2", 64'(bus.in_ready), 64'd1);
      step();
      check_beat("stl.out2", 32'h208);
      drive(1'b0, 32'h0, 1'b0);
      step();
      check("stl.empty", 64'(bus.out_valid), 64'd0);
      check("stl.stall", 64'(bus.stall_cycles), 64'd3);

      // Flush with a full buffer and a beat offered in the same cycle
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h300, 1'b0);
      step();
      drive(1'b1, 32'h304, 1'b0);
      step();
      check("fl.state", 64'(bus.dbg_state), 64'(ST_FULL));
      drive(1'b1, 32'h308, 1'b0);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      bus.out_ready = 1'b1;
      check("fl.valid", 64'(bus.out_valid), 64'd0);
      check("fl.ins",   64'(bus.out_ins), 64'h13);
      check("fl.ready", 64'(bus.in_ready), 64'd1);
      check("fl.stall", 64'(bus.stall_cycles), 64'd5);
      step();
      check("fl.novalid1", 64'(bus.out_valid), 64'd0);
      step();
      check("fl.novalid2", 64'(bus.out_valid), 64'd0);

      // Fault tag follows its beat only
      drive(1'b1, 32'h400, 1'b0);
      step();
      check_beat("flt0", 32'h400);
      check("flt0.fault", 64'(bus.out_fault), 64'd0);
      drive(1'b1, 32'h404, 1'b1);
      step();
      check_beat("flt1", 32'h404);
      check("flt1.fault", 64'(bus.out_fault), 64'd1);
      drive(1'b0, 32'h0, 1'b0);
      step();
      check("flt.idle.valid", 64'(bus.out_valid), 64'd0);
      check("flt.idle.fault", 64'(bus.out_fault), 64'd0);
      check("flt.idle.pc",    64'(bus.out_pc), 64'h404);

      // Asynchronous reset with two entries held
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h500, 1'b0);
      step();
      drive(1'b1, 32'h504, 1'b0);
      step();
      check("ar.state", 64'(bus.dbg_state), 64'(ST_FULL));
      check("ar.stall", 64'(bus.stall_cycles), 64'd6);
      #2;
      rst = 1'b1;
      #1;
      check("ar.valid", 64'(bus.out_valid), 64'd0);
      check("ar.ins",   64'(bus.out_ins), 64'h13);
      check("ar.ready", 64'(bus.in_ready), 64'd1);
      check("ar.stall0", 64'(bus.stall_cycles), 64'd0);
      check("ar.pc",    64'(bus.out_pc), 64'd0);
      drive(1'b0, 32'h0, 1'b0);
      step();
      rst = 1'b0;
      step();
      check("ar.after", 64'(bus.out_valid), 64'd0);

      // Saturation of the 4-bit stall counter, untouched by flush
      drive(1'b1, 32'h600, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 20; i++) step();
      check("sat.stall", 64'(bus.stall_cycles), 64'd15);
      check_beat("sat.hold", 32'h600);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      check("sat.flush.stall", 64'(bus.stall_cycles), 64'd15);
      check("sat.flush.valid", 64'(bus.out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Next-generation IF/ID pipeline boundary.
- Replaces the free-running register with a parametrised, valid/ready-handshaked 2-entry skid buffer.
- Adds flush, NOP bubble injection, a fetch-fault tag and a saturating stall counter.
- Sits between fetch and decode in each core; absorbs a decode stall without a combinational ready path back into fetch.

Parameters:
- INSN_W, 32, instruction width in bits
- PC_W, 32, PC width in bits
- NOP_INSN, 32'h00000013, instruction presented when the output is invalid or after reset (addi x0,x0,0)
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous kill of all buffered entries (branch mispredict / trap)
- in_valid  input  1  fetch presents a beat
- in_ready  output  1  buffer accepts a beat this cycle
- in_ins  input  INSN_W  fetched instruction
- in_pc  input  PC_W  PC of the instruction
- in_pc_plus_4  input  PC_W  sequential next PC
- in_fault  input  1  fetch access fault for this beat
- out_valid  output  1  decode-side beat valid
- out_ready  input  1  decode accepts the beat
- out_ins  output  INSN_W  instruction to decode
- out_pc  output  PC_W  PC to decode
- out_pc_plus_4  output  PC_W  next PC to decode
- out_fault  output  1  fault tag to decode
- stall_cycles  output  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async on rst high):
  - state=EMPTY; out_valid=0; in_ready=1
  - out_ins=NOP_INSN; out_pc=0; out_pc_plus_4=0; out_fault=0
  - stall_cycles=0; skid entry cleared
- Storage: main entry (drives outputs) plus one skid entry.
- in_ready is driven from a register: in_ready = (state != FULL). There is no combinational path from out_ready to in_ready.
- Handshake fire: push = in_valid & in_ready; pop = out_valid & out_ready.
- Output mux: out_ins = out_valid ? main_ins : NOP_INSN; out_fault = out_valid & main_fault. out_pc and out_pc_plus_4 show main contents regardless of validity.
- States and transitions (at clk edge, flush=0):
  - EMPTY: push -> load main, go ONE.
  - ONE:
    - push & pop -> load main with the new beat, stay ONE.
    - push & !pop -> load skid, go FULL.
    - pop & !push -> go EMPTY.
    - neither -> hold.
  - FULL: pop -> main<=skid, go ONE. No push is possible because in_ready=0.
- Latency: 1 cycle from push to out_valid when EMPTY. Throughput is 1 beat/cycle with out_ready held high.
- Ordering: strictly FIFO, with no beat dropped or duplicated.
- Held beats: data and valid stay stable while out_valid=1 and out_ready=0, per the standard valid/ready rules.
- Flush:
  - Highest priority; next state EMPTY and out_valid=0.
  - The push in the flush cycle is discarded. A pop in the flush cycle still counts as consumed by decode.
  - in_ready=1 in the cycle after flush.
- stall_cycles increments when out_valid & !out_ready, saturates at all-ones, and is cleared only by rst (not by flush).
- Reset mid-operation: all entries are discarded immediately, with outputs at reset values asynchronously.
- Fault beats travel like normal beats. The buffer never interprets instructions.

Decomposition:
- Shared package if_id_pkg:
  - NOP_INSN constant (32'h00000013)
  - state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2
  - packed beat struct {ins, pc, pc_plus_4, fault}
- One natural sub-module: if_id_stall_counter, the saturating counter. The skid datapath stays inline.

Test Plan:
- Reset: assert rst mid-cycle with two entries held -> out_valid=0, out_ins=32'h00000013, in_ready=1, stall_cycles=0, all asynchronous.
- Streaming: push pc=0x100,0x104,0x108 on back-to-back cycles with out_ready=1 -> one cycle later, outputs show 0x100,0x104,0x108 in order; out_pc_plus_4=pc+4; in_ready stays 1.
- Stall/skid: push 0x200,0x204 with out_ready=0 -> state FULL, in_ready=0 at the next edge, out_pc holds 0x200 while the 0x208 beat offered on in_valid is not accepted; raise out_ready -> 0x200,0x204,0x208 delivered with no loss; stall_cycles equals the number of stalled cycles.
- Flush: FULL with 0x300,0x304, assert flush together with in_valid (0x308) -> next cycle out_valid=0, out_ins=NOP, in_ready=1; beat 0x308 is never emitted.
- Fault tag: push in_fault=1, pc=0x400 -> out_fault=1 exactly for that beat; out_fault=0 whenever out_valid=0.
- Saturation: with STALL_CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15; flush leaves it at 15.
